// File: rtl/traffic_light_pkg.sv
// Shared types, lamp encodings and default phase lengths for the
// two-road traffic light controller. Optional build macro: ALL_RED_EN.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        SIDE_LEFT   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        MAIN_LEFT   = 3'd5,
        ALL_RED     = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam int DEF_T_GREEN  = 20;
    localparam int DEF_T_YELLOW = 3;
    localparam int DEF_T_LEFT   = 5;
    localparam int DEF_T_ALLRED = 2;

    typedef struct packed {
        logic [2:0] main_road;
        logic [2:0] side_road;
        logic       main_left;
        logic       side_left;
    } lamps_t;

    // Lamp pattern shown in each state; anything not listed is all-red.
    function automatic lamps_t lamp_decode(input state_t s);
        lamps_t l;
        l.main_road = LAMP_RED;
        l.side_road = LAMP_RED;
        l.main_left = 1'b0;
        l.side_left = 1'b0;
        case (s)
            MAIN_GREEN:  l.main_road = LAMP_GRN;
            MAIN_YELLOW: l.main_road = LAMP_YEL;
            SIDE_LEFT:   l.side_left = 1'b1;
            SIDE_GREEN:  l.side_road = LAMP_GRN;
            SIDE_YELLOW: l.side_road = LAMP_YEL;
            MAIN_LEFT:   l.main_left = 1'b1;
            default:     ;
        endcase
        return l;
    endfunction

    // Phase that follows a yellow or left-turn phase. Left-turn phases are
    // skipped when the matching road has no vehicle waiting.
    function automatic state_t ring_after(input state_t from,
                                          input logic   main_s,
                                          input logic   side_s);
        state_t n;
        case (from)
            MAIN_YELLOW: n = side_s ? SIDE_LEFT : SIDE_GREEN;
            SIDE_LEFT:   n = SIDE_GREEN;
            SIDE_YELLOW: n = main_s ? MAIN_LEFT : MAIN_GREEN;
            default:     n = MAIN_GREEN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_light_controller_phase_timer.sv
// Phase timer: 5-bit up-counter with synchronous clear and hold.
// done flags the last cycle of a phase (count == limit-1).
module phase_timer
    import traffic_light_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       hold,
    input  logic [4:0] limit,
    output logic [4:0] count,
    output logic       done
);

    // Count cycles in the current phase; clear wins over hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 5'd0;
        end else if (clear) begin
            count <= 5'd0;
        end else if (!hold) begin
            count <= count + 5'd1;
        end
    end

    // Last cycle of the phase.
    always_comb begin
        done = (count == (limit - 5'd1));
    end

endmodule

// File: rtl/traffic_light_controller.sv
// Two-road intersection sequencer with protected left-turn phases.
// Ring: MAIN_GREEN -> MAIN_YELLOW -> SIDE_LEFT -> SIDE_GREEN -> SIDE_YELLOW
//       -> MAIN_LEFT -> MAIN_GREEN, greens held on demand, lefts skippable.
// Optional build macro ALL_RED_EN inserts an ALL_RED clearance after every
// yellow and left-turn phase.
// Handshake: none; sensors are level inputs sampled only on a phase's last
// cycle (counter == T-1), lamps are registered and change only on clk.
// state_dbg exposes the FSM state register for checkers.
module traffic_light_controller
    import traffic_light_pkg::*;
#(
    parameter int T_GREEN  = DEF_T_GREEN,
    parameter int T_YELLOW = DEF_T_YELLOW,
    parameter int T_LEFT   = DEF_T_LEFT
`ifdef ALL_RED_EN
    ,
    parameter int T_ALLRED = DEF_T_ALLRED
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       main_sensor,
    input  logic       side_sensor,
    output logic [2:0] main_road,
    output logic [2:0] side_road,
    output logic [4:0] counter,
    output logic       main_turn_left,
    output logic       side_turn_left,
    output logic [2:0] state_dbg
);

    state_t     state;
    state_t     nxt;
    lamps_t     nxt_lamps;
    logic [4:0] limit;
    logic       done;
    logic       clear;
    logic       hold;

`ifdef ALL_RED_EN
    // Phase that led into ALL_RED, so the clearance knows where to go next.
    state_t     prev_state;
`endif

    // Length of the phase currently being timed.
    always_comb begin
        limit = 5'(T_GREEN);
        case (state)
            MAIN_GREEN, SIDE_GREEN:  limit = 5'(T_GREEN);
            MAIN_YELLOW, SIDE_YELLOW: limit = 5'(T_YELLOW);
            MAIN_LEFT, SIDE_LEFT:    limit = 5'(T_LEFT);
`ifdef ALL_RED_EN
            ALL_RED:                 limit = 5'(T_ALLRED);
`endif
            default:                 limit = 5'(T_GREEN);
        endcase
    end

    // Next-state decision, evaluated only on the last cycle of a phase.
    always_comb begin
        nxt = state;
        if (done) begin
            case (state)
                MAIN_GREEN: begin
                    if (side_sensor) nxt = MAIN_YELLOW;
                end
                SIDE_GREEN: begin
                    if (!side_sensor || main_sensor) nxt = SIDE_YELLOW;
                end
                MAIN_YELLOW, SIDE_LEFT, SIDE_YELLOW, MAIN_LEFT: begin
`ifdef ALL_RED_EN
                    nxt = ALL_RED;
`else
                    nxt = ring_after(state, main_sensor, side_sensor);
`endif
                end
`ifdef ALL_RED_EN
                ALL_RED: begin
                    nxt = ring_after(prev_state, main_sensor, side_sensor);
                end
`endif
                default: nxt = MAIN_GREEN;
            endcase
        end
    end

    // Restart the timer on a phase change; freeze it while a green is held.
    always_comb begin
        clear     = (nxt != state);
        hold      = done && !clear;
        nxt_lamps = lamp_decode(nxt);
    end

    phase_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .hold  (hold),
        .limit (limit),
        .count (counter),
        .done  (done)
    );

    // State register with lamp outputs registered from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= MAIN_GREEN;
            main_road      <= LAMP_GRN;
            side_road      <= LAMP_RED;
            main_turn_left <= 1'b0;
            side_turn_left <= 1'b0;
`ifdef ALL_RED_EN
            prev_state     <= MAIN_GREEN;
`endif
        end else begin
            state          <= nxt;
            main_road      <= nxt_lamps.main_road;
            side_road      <= nxt_lamps.side_road;
            main_turn_left <= nxt_lamps.main_left;
            side_turn_left <= nxt_lamps.side_left;
`ifdef ALL_RED_EN
            if (nxt == ALL_RED && state != ALL_RED) prev_state <= state;
`endif
        end
    end

    // Debug view of the FSM state.
    always_comb begin
        state_dbg = state;
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller (default build, ALL_RED_EN undefined).
module tb_traffic_light_controller;

    localparam int W = 16;

    logic       clk;
    logic       rst_n;
    logic       main_sensor;
    logic       side_sensor;
    logic [2:0] main_road;
    logic [2:0] side_road;
    logic [4:0] counter;
    logic       main_turn_left;
    logic       side_turn_left;
    logic [2:0] state_dbg;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] dut_vec;
    logic [W-1:0] reset_vec;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // reference model: phase index (0 MG,1 MY,2 SL,3 SG,4 SY,5 ML) and count
    int mph  = 0;
    int mcnt = 0;
    int cyc  = 0;
    int entries[$];

    traffic_light_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .main_sensor    (main_sensor),
        .side_sensor    (side_sensor),
        .main_road      (main_road),
        .side_road      (side_road),
        .counter        (counter),
        .main_turn_left (main_turn_left),
        .side_turn_left (side_turn_left),
        .state_dbg      (state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #10 clk = ~clk;

    assign dut_vec   = {state_dbg, main_road, side_road, counter, main_turn_left, side_turn_left};
    assign reset_vec = {3'd0, 3'b001, 3'b100, 5'd0, 1'b0, 1'b0};

    function automatic logic [W-1:0] model_vec(input int ph, input int cnt);
        logic [2:0] m;
        logic [2:0] s;
        m = (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
        s = (ph == 3) ? 3'b001 : (ph == 4) ? 3'b010 : 3'b100;
        return {3'(ph), m, s, 5'(cnt), (ph == 5), (ph == 2)};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        assert_cnt++;
        assert (got === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_advance(input logic m, input logic s);
        int len;
        int nph;
        len = (mph == 0 || mph == 3) ? 20 : (mph == 1 || mph == 4) ? 3 : 5;
        if (mcnt < len - 1) begin
            mcnt++;
        end else begin
            nph = mph;
            case (mph)
                0: if (s) nph = 1;
                1: nph = s ? 2 : 3;
                2: nph = 3;
                3: if (!s || m) nph = 4;
                4: nph = m ? 5 : 0;
                default: nph = 0;
            endcase
            if (nph != mph) begin
                mph  = nph;
                mcnt = 0;
            end
        end
    endtask

    // driver: apply sensors for one cycle, predict, compare after the edge
    task automatic step(input logic m, input logic s);
        main_sensor = m;
        side_sensor = s;
        model_advance(m, s);
        exp_q.push_back(model_vec(mph, mcnt));
        @(posedge clk);
        #1;
        cyc++;
        check("cycle", dut_vec, exp_q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        main_sensor = 1'b0;
        side_sensor = 1'b0;
        #25;
        check("reset_state", dut_vec, reset_vec);
        @(negedge clk);
        rst_n = 1'b1;
        mph   = 0;
        mcnt  = 0;

        // main only: MAIN_GREEN holds at 19
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
        check("main_hold", {state_dbg, main_road, counter}, {3'd0, 3'b001, 5'd19});

        // both sensors: full ring, MAIN_GREEN re-entered every 56 cycles
        for (int i = 0; i < 130; i++) begin
            step(1'b1, 1'b1);
            if (state_dbg == 3'd0 && counter == 5'd0) entries.push_back(cyc);
        end
        check("ring_entries", 16'(entries.size() >= 2), 16'd1);
        check("ring_period", 16'((entries.size() >= 2) ? entries[1] - entries[0] : 0), 16'd56);

        // side only: SIDE_GREEN holds, MAIN_LEFT skipped
        for (int i = 0; i < 80; i++) step(1'b0, 1'b1);
        check("side_hold", {state_dbg, side_road, counter}, {3'd3, 3'b001, 5'd19});

        // random sensors, changing mid-phase
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // steer into SIDE_GREEN, then reset asynchronously mid-phase
        for (int i = 0; i < 120 && !(mph == 3 && mcnt >= 6); i++) step(1'b0, 1'b1);
        check("pre_reset_sg", {13'd0, state_dbg}, {13'd0, 3'd3});
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_vec, reset_vec);
        @(posedge clk);
        #1;
        check("reset_hold", dut_vec, reset_vec);
        @(negedge clk);
        rst_n = 1'b1;
        mph   = 0;
        mcnt  = 0;

        // no demand: stays in MAIN_GREEN
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0);
        check("idle_main", {state_dbg, main_road, side_road, counter}, {3'd0, 3'b001, 3'b100, 5'd19});

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
